clk_int_div_gen: RTL

Programmable integer clock divider. It derives a divided clock `clk_o` from `clk_i`, with the ratio changed at runtime through a valid/ready handshake. The new ratio takes effect only on an output-period boundary, so `clk_o` never produces a runt pulse. The output gating and bypass path are built from the behavioural clock cells `clk_an2`, `clk_mux2` and `clk_buf`, so the ASIC flow can swap in real cells. Typical users are peripheral clock generators (SPI/I2C/UART baud clocks, timers) in the SoC clock tree.

---
 rtl/clk_div_pkg.sv | 11 +
 rtl/clk_cells.sv | 25 ++
 rtl/clk_int_div_core.sv | 92 +++++++++
 rtl/clk_int_div_gen.sv | 78 +++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the integer clock divider: default divisor width,
// divisor type and the largest divisor value that selects the bypass path.
package clk_div_pkg;

  localparam int DEF_DIV_WIDTH = 8;

  localparam int unsigned BYPASS_MAX = 1;

  typedef logic [DEF_DIV_WIDTH-1:0] div_t;

endpackage

// File: rtl/clk_cells.sv
// Behavioural clock cells. Kept as separate modules so the ASIC flow can
// replace them with dedicated clock-tree library cells.
module clk_an2 (
  input  logic i_a,
  input  logic i_b,
  output logic o_z
);
  assign o_z = i_a & i_b;
endmodule

module clk_mux2 (
  input  logic i_d0,
  input  logic i_d1,
  input  logic i_sel,
  output logic o_z
);
  assign o_z = i_sel ? i_d1 : i_d0;
endmodule

module clk_buf (
  input  logic i_a,
  output logic o_z
);
  assign o_z = i_a;
endmodule

// File: rtl/clk_int_div_core.sv
// Posedge half of the divider: period counter, registered divided clock,
// run flag and the valid/ready divisor hand-over that only lands on a
// period boundary.
module clk_int_div_core
  import clk_div_pkg::*;
#(
  parameter int          DIV_WIDTH = DEF_DIV_WIDTH,
  parameter int unsigned DEF_DIV   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 div_valid_i,
  output logic                 div_ready_o,
  output logic                 busy_o,
  output logic                 clk_div_o,
  output logic                 run_o,
  output logic                 bypass_o
);

  localparam logic [DIV_WIDTH-1:0] DEF_DIV_W = DIV_WIDTH'(DEF_DIV);
  localparam logic [DIV_WIDTH-1:0] BYP_MAX_W = DIV_WIDTH'(BYPASS_MAX);
  localparam logic [DIV_WIDTH-1:0] ONE_W     = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH:0]   ONE_WX    = (DIV_WIDTH+1)'(1);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_pend_q;
  logic                 pend_q;
  logic                 run_q;
  logic                 clk_div_q;

  logic                 w_bypass;
  logic                 w_last;
  logic                 w_boundary;
  logic                 w_xfer;
  logic                 w_high;
  logic [DIV_WIDTH:0]   w_half;

  // In bypass every cycle is a period boundary; otherwise the wrap compare
  // uses div_q-1 at full width so the largest divisor cannot overflow cnt_q.
  assign w_bypass   = (div_q <= BYP_MAX_W);
  assign w_last     = w_bypass ? 1'b1 : (cnt_q == (div_q - ONE_W));
  assign w_boundary = ~run_q | w_last;
  assign w_xfer     = div_valid_i & ~pend_q;

  // High time is ceil(N/2), computed one bit wider so N = 2^W-1 still fits.
  assign w_half = ({1'b0, div_q} + ONE_WX) >> 1;
  assign w_high = run_q & ~w_bypass & ({1'b0, cnt_q} < w_half);

  // Counter, run flag and the registered divided clock advance every cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      run_q     <= 1'b0;
      clk_div_q <= 1'b0;
    end else begin
      clk_div_q <= w_high;
      if (w_boundary) begin
        cnt_q <= '0;
        run_q <= en_i;
      end else begin
        cnt_q <= cnt_q + ONE_W;
      end
    end
  end

  // Capture a divisor on transfer and hand it over only at a later boundary.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q      <= DEF_DIV_W;
      div_pend_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      if (w_boundary && pend_q) begin
        div_q  <= div_pend_q;
        pend_q <= 1'b0;
      end else if (w_xfer) begin
        div_pend_q <= div_i;
        pend_q     <= 1'b1;
      end
    end
  end

  assign div_ready_o = ~pend_q;
  assign busy_o      = pend_q;
  assign clk_div_o   = clk_div_q;
  assign run_o       = run_q;
  assign bypass_o    = w_bypass;

endmodule

// File: rtl/clk_int_div_gen.sv
// Programmable integer clock divider top. Adds the falling-edge retiming of
// the bypass select and run enable, then builds clk_o from clock cells so
// both the bypass switch and the enable gate only move while clk_i is low.
module clk_int_div_gen
  import clk_div_pkg::*;
#(
  parameter int          DIV_WIDTH = DEF_DIV_WIDTH,
  parameter int unsigned DEF_DIV   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 div_valid_i,
  output logic                 div_ready_o,
  output logic                 clk_o,
  output logic                 busy_o
);

  localparam logic BYP_RST = (DEF_DIV <= BYPASS_MAX);

  logic w_clk_div;
  logic w_run;
  logic w_bypass;
  logic w_mux;
  logic w_gated;
  logic byp_q;
  logic run_q_neg;

  clk_int_div_core #(
    .DIV_WIDTH (DIV_WIDTH),
    .DEF_DIV   (DEF_DIV)
  ) u_core (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .en_i        (en_i),
    .div_i       (div_i),
    .div_valid_i (div_valid_i),
    .div_ready_o (div_ready_o),
    .busy_o      (busy_o),
    .clk_div_o   (w_clk_div),
    .run_o       (w_run),
    .bypass_o    (w_bypass)
  );

  // Retime select and enable on the falling edge; the select only moves while
  // the divided clock is low so both mux inputs are low at the switch.
  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      byp_q     <= BYP_RST;
      run_q_neg <= 1'b0;
    end else begin
      run_q_neg <= w_run;
      if (!w_clk_div) begin
        byp_q <= w_bypass;
      end
    end
  end

  clk_mux2 u_mux (
    .i_d0  (w_clk_div),
    .i_d1  (clk_i),
    .i_sel (byp_q),
    .o_z   (w_mux)
  );

  clk_an2 u_gate (
    .i_a (w_mux),
    .i_b (run_q_neg),
    .o_z (w_gated)
  );

  clk_buf u_obuf (
    .i_a (w_gated),
    .o_z (clk_o)
  );

endmodule
